lane_dispatcher: RTL and testbench

- Issue-side counterpart of the vector lane instruction handshake.
- Buffers vector arithmetic instructions and their scalar operand from the scalar core in a small FIFO.
- Broadcasts each instruction to all LANES lanes with a one-cycle request, holds the operand stable, and retires the instruction once every lane has pulsed its ready.
- Sits between the scalar core's vector issue port and the lane array.

---
 rtl/lane_dispatcher.sv | 127 ++++++++++++
 tb/tb_lane_dispatcher.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_dispatcher.sv
// Issue-side vector lane dispatcher: buffers {instruction, scalar operand} pairs,
// broadcasts the FIFO head to all lanes and retires it once every lane reports ready.
module lane_dispatcher #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LANES      = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned INSTR_W    = 32
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic                  instr_valid_i,
    input  logic [INSTR_W-1:0]    instr_i,
    input  logic [DATA_WIDTH-1:0] rs1_rdata_i,
    output logic                  instr_ready_o,
    output logic [LANES-1:0]      lane_instr_req_o,
    output logic [INSTR_W-1:0]    lane_instr_o,
    output logic [DATA_WIDTH-1:0] lane_rs1_rdata_o,
    input  logic [LANES-1:0]      lane_ready_i,
    output logic                  done_o,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_RETIRE = 2'd3
    } state_e;

    state_e                r_state;
    state_e                w_state_nxt;
    logic [INSTR_W-1:0]    r_instr_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_data_mem  [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [CNT_W-1:0]      r_count;
    logic [LANES-1:0]      r_done_bits;
    logic [LANES-1:0]      w_done_bits_nxt;
    logic                  r_err;
    logic                  w_err_set;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_all_done;

    assign instr_ready_o    = (r_count != CNT_W'(FIFO_DEPTH));
    assign w_push           = instr_valid_i && instr_ready_o;
    assign w_all_done       = &(r_done_bits | lane_ready_i);
    assign lane_instr_o     = (r_count != '0) ? r_instr_mem[r_rptr] : '0;
    assign lane_rs1_rdata_o = (r_count != '0) ? r_data_mem[r_rptr]  : '0;
    assign busy_o           = (r_state != S_IDLE) || (r_count != '0);
    assign err_o            = r_err;

    // Payload storage; contents are don't-care while the slot is not counted.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_instr_mem[r_wptr] <= instr_i;
            r_data_mem[r_wptr]  <= rs1_rdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state     <= S_IDLE;
            r_done_bits <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_done_bits <= w_done_bits_nxt;
            r_err       <= r_err | w_err_set;
        end
    end

    // Stray or duplicate ready pulses only raise err; they never advance the FSM.
    always_comb begin
        w_state_nxt      = r_state;
        w_done_bits_nxt  = r_done_bits;
        w_err_set        = 1'b0;
        w_pop            = 1'b0;
        lane_instr_req_o = '0;
        done_o           = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_err_set = |lane_ready_i;
                if (r_count != '0) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                lane_instr_req_o = '1;
                w_done_bits_nxt  = r_done_bits | lane_ready_i;
                w_state_nxt      = S_WAIT;
            end
            S_WAIT: begin
                w_err_set       = |(lane_ready_i & r_done_bits);
                w_done_bits_nxt = r_done_bits | lane_ready_i;
                if (w_all_done) w_state_nxt = S_RETIRE;
            end
            S_RETIRE: begin
                done_o          = 1'b1;
                w_pop           = 1'b1;
                w_err_set       = |lane_ready_i;
                w_done_bits_nxt = '0;
                w_state_nxt     = ((r_count > CNT_W'(1)) || w_push) ? S_ISSUE : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_lane_dispatcher.sv
// Self-checking bench for lane_dispatcher: directed tables/sequences plus random
// traffic against a transaction-timeline reference model.
module tb_lane_dispatcher;

    localparam int unsigned DW    = 32;
    localparam int unsigned NL    = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned IW    = 32;

    logic          clk_i;
    logic          resetn_i;
    logic          instr_valid_i;
    logic [IW-1:0] instr_i;
    logic [DW-1:0] rs1_rdata_i;
    logic          instr_ready_o;
    logic [NL-1:0] lane_instr_req_o;
    logic [IW-1:0] lane_instr_o;
    logic [DW-1:0] lane_rs1_rdata_o;
    logic [NL-1:0] lane_ready_i;
    logic          done_o;
    logic          busy_o;
    logic          err_o;

    lane_dispatcher #(.DATA_WIDTH(DW), .LANES(NL), .FIFO_DEPTH(DEPTH), .INSTR_W(IW)) dut (
        .clk_i(clk_i), .resetn_i(resetn_i), .instr_valid_i(instr_valid_i),
        .instr_i(instr_i), .rs1_rdata_i(rs1_rdata_i), .instr_ready_o(instr_ready_o),
        .lane_instr_req_o(lane_instr_req_o), .lane_instr_o(lane_instr_o),
        .lane_rs1_rdata_o(lane_rs1_rdata_o), .lane_ready_i(lane_ready_i),
        .done_o(done_o), .busy_o(busy_o), .err_o(err_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    int checks = 0;
    int errors = 0;

    // Reference model: queue of buffered instructions plus the cycle numbers at
    // which the head is issued and retired.
    typedef struct packed {
        logic [IW-1:0] ins;
        logic [DW-1:0] d;
    } ent_t;
    ent_t          q[$];
    int            issue_at;
    int            retire_at;
    int            cyc;
    logic [NL-1:0] got;
    bit            merr;
    logic [IW-1:0] dut_ret[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d act=%h exp=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        issue_at  = -1;
        retire_at = -1;
        cyc       = 0;
        got       = '0;
        merr      = 1'b0;
    endtask

    function automatic bit m_active();
        return (issue_at >= 0) && (cyc >= issue_at) && (retire_at < 0);
    endfunction

    task automatic model_check();
        logic [IW-1:0] e_ins;
        logic [DW-1:0] e_d;
        e_ins = (q.size() != 0) ? q[0].ins : '0;
        e_d   = (q.size() != 0) ? q[0].d   : '0;
        chk("instr_ready", 32'(instr_ready_o), 32'(q.size() < DEPTH));
        chk("req", 32'(lane_instr_req_o), (cyc == issue_at) ? 32'hF : 32'h0);
        chk("done", 32'(done_o), 32'(cyc == retire_at));
        chk("lane_instr", lane_instr_o, e_ins);
        chk("lane_rs1", lane_rs1_rdata_o, e_d);
        chk("busy", 32'(busy_o), 32'(q.size() != 0));
        chk("err", 32'(err_o), 32'(merr));
        if (done_o) dut_ret.push_back(lane_instr_o);
    endtask

    task automatic model_update();
        bit   active;
        bit   in_wait;
        bit   push;
        ent_t e;
        active  = m_active();
        in_wait = active && (cyc > issue_at);
        if (!active && lane_ready_i != '0) merr = 1'b1;
        if (in_wait && (lane_ready_i & got) != '0) merr = 1'b1;
        if (active) got |= lane_ready_i;
        push = instr_valid_i && (q.size() < DEPTH);
        e.ins = instr_i;
        e.d   = rs1_rdata_i;
        if (cyc == retire_at) begin
            void'(q.pop_front());
            got       = '0;
            retire_at = -1;
            if (push) q.push_back(e);
            issue_at = (q.size() != 0) ? cyc + 1 : -1;
        end else begin
            if (in_wait && got == 4'hF) retire_at = cyc + 1;
            if (push) begin
                if (q.size() == 0) issue_at = cyc + 2;
                q.push_back(e);
            end
        end
        cyc++;
    endtask

    task automatic drive(input logic v, input logic [IW-1:0] ins, input logic [DW-1:0] d,
                         input logic [NL-1:0] rdy);
        instr_valid_i = v;
        instr_i       = ins;
        rs1_rdata_i   = d;
        lane_ready_i  = rdy;
        #1;
        model_check();
    endtask

    task automatic advance();
        model_update();
        @(posedge clk_i);
        #1;
    endtask

    task automatic cycle(input logic v, input logic [IW-1:0] ins, input logic [DW-1:0] d,
                         input logic [NL-1:0] rdy);
        drive(v, ins, d, rdy);
        advance();
    endtask

    task automatic do_reset();
        resetn_i      = 1'b0;
        instr_valid_i = 1'b0;
        instr_i       = '0;
        rs1_rdata_i   = '0;
        lane_ready_i  = '0;
        repeat (2) @(posedge clk_i);
        #1;
        resetn_i = 1'b1;
        model_reset();
        dut_ret.delete();
    endtask

    typedef struct {
        logic          v;
        logic [IW-1:0] ins;
        logic [DW-1:0] d;
        logic [NL-1:0] rdy;
        logic [NL-1:0] e_req;
        logic          e_done;
        logic          e_busy;
        logic [DW-1:0] e_rs1;
    } vec_t;
    vec_t tbl[11];

    logic [IW-1:0] fa[5];
    logic [DW-1:0] fd[5];

    initial begin
        int            dcnt;
        int            dcyc;
        int            k;
        logic [NL-1:0] r;

        model_reset();
        resetn_i = 1'b0; instr_valid_i = 1'b0; instr_i = '0; rs1_rdata_i = '0; lane_ready_i = '0;
        #2;
        chk("rst_ready", 32'(instr_ready_o), 32'h1);
        chk("rst_req", 32'(lane_instr_req_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_done_err", {30'h0, done_o, err_o}, 32'h0);
        do_reset();

        // Single instruction: table of per-cycle inputs and expected outputs.
        for (int i = 0; i < 11; i++)
            tbl[i] = '{v: 1'b0, ins: '0, d: '0, rdy: '0, e_req: '0, e_done: 1'b0,
                       e_busy: 1'b1, e_rs1: 32'hDEAD_BEEF};
        tbl[0].v = 1'b1; tbl[0].ins = 32'h0000_0057; tbl[0].d = 32'hDEAD_BEEF;
        tbl[0].e_busy = 1'b0; tbl[0].e_rs1 = '0;
        tbl[2].e_req  = 4'hF;
        tbl[8].rdy    = 4'hF;
        tbl[9].e_done = 1'b1;
        tbl[10].e_busy = 1'b0; tbl[10].e_rs1 = '0;
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].v, tbl[i].ins, tbl[i].d, tbl[i].rdy);
            chk("tbl_req", 32'(lane_instr_req_o), 32'(tbl[i].e_req));
            chk("tbl_done", 32'(done_o), 32'(tbl[i].e_done));
            chk("tbl_busy", 32'(busy_o), 32'(tbl[i].e_busy));
            chk("tbl_rs1", lane_rs1_rdata_o, tbl[i].e_rs1);
            advance();
        end

        // Staggered ready: lane0 @5, lanes1,2 @7, lane3 @12 -> single done @13.
        do_reset();
        dcnt = 0; dcyc = -1;
        for (int c = 0; c < 16; c++) begin
            r = (c == 5) ? 4'b0001 : (c == 7) ? 4'b0110 : (c == 12) ? 4'b1000 : 4'b0000;
            drive(c == 0, 32'h0000_0011, 32'h1234_5678, r);
            if (done_o) begin dcnt++; dcyc = c; end
            advance();
        end
        chk("stagger_done_cnt", 32'(dcnt), 32'd1);
        chk("stagger_done_cyc", 32'(dcyc), 32'd13);

        // Fill and back-pressure with stalled lanes, then drain in order.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            fa[i] = 32'hA000_0000 + 32'(i);
            fd[i] = 32'h5000_0000 + 32'(i * 3);
        end
        k = 0;
        for (int c = 0; c < 40; c++) begin
            r = (c > 5 && m_active()) ? ~got : 4'h0;
            drive(k < 5, fa[(k < 5) ? k : 4], fd[(k < 5) ? k : 4], r);
            if (c == 4) chk("fill_full_ready", 32'(instr_ready_o), 32'h0);
            if (c == 4) chk("fill_accepted", 32'(k), 32'd4);
            if (instr_ready_o && k < 5) k++;
            advance();
        end
        chk("fill_retired_cnt", 32'(dut_ret.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            if (i < dut_ret.size()) chk("fill_order", dut_ret[i], fa[i]);

        // Push during RETIRE with a single entry goes straight back to ISSUE.
        do_reset();
        cycle(1'b1, 32'h0000_00C1, 32'hC0DE_0001, 4'h0);
        cycle(1'b0, '0, '0, 4'h0);
        cycle(1'b0, '0, '0, 4'hF);
        cycle(1'b0, '0, '0, 4'h0);
        drive(1'b1, 32'h0000_00C2, 32'hC0DE_0002, 4'h0);
        chk("retpush_done", 32'(done_o), 32'h1);
        advance();
        drive(1'b0, '0, '0, 4'h0);
        chk("retpush_req", 32'(lane_instr_req_o), 32'hF);
        chk("retpush_head", lane_instr_o, 32'h0000_00C2);
        chk("retpush_rs1", lane_rs1_rdata_o, 32'hC0DE_0002);
        advance();

        // Stray ready in IDLE.
        do_reset();
        cycle(1'b0, '0, '0, 4'b0100);
        for (int c = 1; c < 5; c++) begin
            drive(1'b0, '0, '0, 4'h0);
            chk("idle_err_sticky", 32'(err_o), 32'h1);
            chk("idle_no_busy", 32'(busy_o), 32'h0);
            advance();
        end

        // Duplicate lane0 ready in WAIT: error, no early retire.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            r = (c == 3 || c == 4) ? 4'b0001 : (c == 6) ? 4'b1110 : 4'b0000;
            drive(c == 0, 32'h0000_0D0D, 32'hFACE_0000, r);
            if (c == 5 || c == 6) chk("dup_no_early_done", 32'(done_o), 32'h0);
            if (c == 7) chk("dup_done", 32'(done_o), 32'h1);
            if (c >= 5) chk("dup_err", 32'(err_o), 32'h1);
            advance();
        end

        // Asynchronous reset in WAIT.
        do_reset();
        for (int c = 0; c < 5; c++) cycle(c == 0, 32'h0000_0E0E, 32'h0BAD_F00D, 4'h0);
        #3;
        resetn_i = 1'b0;
        instr_valid_i = 1'b0;
        #1;
        chk("arst_ready", 32'(instr_ready_o), 32'h1);
        chk("arst_busy", 32'(busy_o), 32'h0);
        chk("arst_outs", {28'h0, lane_instr_req_o} | lane_instr_o | lane_rs1_rdata_o
                         | {30'h0, done_o, err_o}, 32'h0);
        model_reset();
        @(posedge clk_i);
        #1;
        resetn_i = 1'b1;
        dcnt = 0;
        for (int c = 0; c < 12; c++) begin
            drive(1'b0, '0, '0, 4'h0);
            if (done_o) dcnt++;
            advance();
        end
        chk("arst_no_done", 32'(dcnt), 32'd0);

        // Random legal traffic against the model.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            r = '0;
            if (m_active())
                for (int l = 0; l < NL; l++)
                    if (!got[l] && $urandom_range(0, 3) == 0) r[l] = 1'b1;
            cycle(1'($urandom_range(0, 1)), IW'($urandom), DW'($urandom), r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
